// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: widths, requester indices,
// the broadcast packet type and the round-robin pointer helper.
package cdb_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester bit positions, shared with pcControl and the reservation stations.
    typedef enum logic [1:0] {
        ADD_RS = 2'd0,
        LW_RS  = 2'd1,
        SW_RS  = 2'd2,
        BNE_RS = 2'd3
    } rs_idx_e;

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [PTR_W-1:0]   ptr_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        req_vec_t          src;
    } cdb_pkt_t;

    // Pointer value that puts the just-granted requester at lowest priority.
    function automatic ptr_t next_ptr(input req_vec_t onehot);
        ptr_t result;
        result = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) begin
                result = ptr_t'((i + 1) % NUM_REQ);
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester / broadcast bundle of the common data bus; the stations and ROB side
// use the master view, the arbiter uses the slave view.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      bus_ready;
    logic                      flush;
    logic [NUM_REQ-1:0]        grant;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [NUM_REQ-1:0]        cdb_src;

    modport master (
        output req, req_tag, req_data, bus_ready, flush,
        input  grant, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  req, req_tag, req_data, bus_ready, flush,
        output grant, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin winner: rotate req so ptr sits at bit 0, take the
// lowest set bit, rotate the one-hot result back into requester order.
module cdb_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic [NUM_REQ-1:0] rot_s;
    logic [NUM_REQ-1:0] first_s;

    // Rotate requests so the highest-priority requester lands at bit 0.
    always_comb begin
        rot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot_s[i] = req[(i + int'(ptr)) % NUM_REQ];
        end
    end

    // Priority-encode the rotated vector to a one-hot.
    always_comb begin
        logic found;
        found   = 1'b0;
        first_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot_s[i]) begin
                first_s[i] = 1'b1;
                found      = 1'b1;
            end else begin
                first_s[i] = 1'b0;
            end
        end
    end

    // Rotate the one-hot winner back into requester bit order.
    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            winner[(i + int'(ptr)) % NUM_REQ] = first_s[i];
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one finished result per cycle is
// granted, registered and broadcast; pcChange (flush) squashes the grant.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    ptr_t                rr_ptr_q;
    ptr_t                rr_ptr_d;
    cdb_pkt_t            cdb_q;
    cdb_pkt_t            cdb_d;
    req_vec_t            pick_s;
    req_vec_t            grant_s;
    logic [TAG_W-1:0]    sel_tag_s;
    logic [DATA_W-1:0]   sel_data_s;

    cdb_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (bus.req),
        .ptr    (rr_ptr_q),
        .winner (pick_s)
    );

    // Reset, a busy ROB or a pc redirect all suppress the grant.
    always_comb begin
        if (reset || !bus.bus_ready || bus.flush) begin
            grant_s = '0;
        end else begin
            grant_s = pick_s;
        end
    end

    // AND-OR mux of the granted requester's tag and data.
    always_comb begin
        sel_tag_s  = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_tag_s  = sel_tag_s  | (bus.req_tag[i*TAG_W +: TAG_W]    & {TAG_W{grant_s[i]}});
            sel_data_s = sel_data_s | (bus.req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
        end
    end

    // Next broadcast and pointer; a stall keeps tag/data/src and the pointer.
    always_comb begin
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        if (|grant_s) begin
            cdb_d.valid = 1'b1;
            cdb_d.tag   = sel_tag_s;
            cdb_d.data  = sel_data_s;
            cdb_d.src   = grant_s;
            rr_ptr_d    = next_ptr(grant_s);
        end else begin
            cdb_d.valid = 1'b0;
        end
    end

    // Broadcast and pointer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            cdb_q    <= cdb_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.grant     = grant_s;
    assign bus.cdb_valid = cdb_q.valid;
    assign bus.cdb_tag   = cdb_q.tag;
    assign bus.cdb_data  = cdb_q.data;
    assign bus.cdb_src   = cdb_q.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic, all checked
// against a behavioural round-robin model kept here.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clock;
    logic reset;
    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: who is next in line, and what the bus should show.
    int          m_ptr;
    logic        m_valid;
    logic [3:0]  m_tag;
    logic [31:0] m_data;
    logic [3:0]  m_src;
    logic [3:0]  exp_g;

    // Expected grant: first pending requester at or after m_ptr, wrapping.
    function automatic logic [3:0] model_grant();
        logic [3:0] g;
        g = 4'd0;
        if (!(reset || !bus.bus_ready || bus.flush)) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (g == 4'd0 && bus.req[idx]) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    // Advance one clock and update the model from the cycle's inputs.
    task automatic tick();
        int gi;
        exp_g = model_grant();
        gi = -1;
        for (int i = 0; i < 4; i++) if (exp_g[i]) gi = i;
        @(posedge clock);
        if (reset) begin
            m_valid = 1'b0; m_tag = 4'd0; m_data = 32'd0; m_src = 4'd0; m_ptr = 0;
        end else if (gi >= 0) begin
            m_valid = 1'b1;
            m_tag   = bus.req_tag[gi*4 +: 4];
            m_data  = bus.req_data[gi*32 +: 32];
            m_src   = exp_g;
            m_ptr   = (gi + 1) % 4;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        bus.req = r;
        for (int i = 0; i < 4; i++) begin
            bus.req_tag[i*4 +: 4]    = 4'(i + 8);
            bus.req_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        end
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.bus_ready = 1'b1; bus.flush = 1'b0;
        set_req(4'b1111);
        n_tests++;
        if (bus.grant !== 4'b0000) begin
            n_fail++; $display("FAIL reset_grant got=%b want=0000", bus.grant);
        end
        tick();
        tick();
        n_tests++;
        if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b t=%h d=%h s=%b want all zero",
                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src);
        end
        reset = 1'b0;
        #2;
        n_tests++;
        if (bus.grant !== 4'b0001) begin
            n_fail++; $display("FAIL reset_ptr_zero got=%b want=0001", bus.grant);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        set_req(4'b1111);
        for (int c = 0; c < 4; c++) begin
            want = 4'b0001 << c;
            n_tests++;
            if (bus.grant !== want) begin
                n_fail++; $display("FAIL rotation_grant%0d got=%b want=%b", c, bus.grant, want);
            end
            tick();
            n_tests++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== want || bus.cdb_tag !== 4'(c + 8)) begin
                n_fail++;
                $display("FAIL rotation_src%0d got v=%b s=%b t=%h want v=1 s=%b t=%h",
                         c, bus.cdb_valid, bus.cdb_src, bus.cdb_tag, want, 4'(c + 8));
            end
        end
    endtask

    task automatic test_single();
        set_req(4'b0000);
        bus.req = 4'b0100;
        bus.req_tag[8 +: 4]   = 4'd5;
        bus.req_data[64 +: 32] = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if (bus.grant !== 4'b0100) begin
            n_fail++; $display("FAIL single_grant got=%b want=0100", bus.grant);
        end
        tick();
        n_tests++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 4'd5 || bus.cdb_data !== 32'hDEAD_BEEF
            || bus.cdb_src !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_bcast got v=%b t=%h d=%h s=%b want v=1 t=5 d=deadbeef s=0100",
                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src);
        end
        bus.req = 4'b0000;
        #1;
        tick();
        n_tests++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 4'd5 || bus.cdb_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL idle_hold got v=%b t=%h d=%h want v=0 t=5 d=deadbeef",
                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
    endtask

    // Pointer sits at 3 here: ready stall, then wrap to 0, then 1.
    task automatic test_stall_wrap();
        bus.bus_ready = 1'b0;
        set_req(4'b0011);
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (bus.grant !== 4'b0000) begin
                n_fail++; $display("FAIL stall_grant%0d got=%b want=0000", c, bus.grant);
            end
            tick();
            n_tests++;
            if (bus.cdb_valid !== 1'b0) begin
                n_fail++; $display("FAIL stall_valid%0d got=%b want=0", c, bus.cdb_valid);
            end
        end
        bus.bus_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.grant !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_grant got=%b want=0001", bus.grant);
        end
        tick();
        n_tests++;
        if (bus.grant !== 4'b0010) begin
            n_fail++; $display("FAIL wrap_next got=%b want=0010", bus.grant);
        end
        tick();
    endtask

    task automatic test_flush();
        bus.flush = 1'b1;
        set_req(4'b1000);
        n_tests++;
        if (bus.grant !== 4'b0000) begin
            n_fail++; $display("FAIL flush_grant got=%b want=0000", bus.grant);
        end
        tick();
        n_tests++;
        if (bus.cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid got=%b want=0", bus.cdb_valid);
        end
        bus.flush = 1'b0;
        #1;
        n_tests++;
        if (bus.grant !== 4'b1000) begin
            n_fail++; $display("FAIL flush_after got=%b want=1000", bus.grant);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(4'b0010);
        tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.grant !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_grant got=%b want=0000", bus.grant);
        end
        tick();
        n_tests++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_data !== 32'd0 || bus.cdb_src !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_out got v=%b d=%h s=%b want zeros",
                     bus.cdb_valid, bus.cdb_data, bus.cdb_src);
        end
        reset = 1'b0;
        #1;
    endtask

    // Random traffic with requesters that hold until granted.
    task automatic test_random();
        logic [3:0] last_g;
        last_g = 4'd0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (last_g[i] || !bus.req[i] || ($urandom_range(0, 15) == 0 && bus.flush)) begin
                    bus.req[i]               = 1'($urandom_range(0, 1));
                    bus.req_tag[i*4 +: 4]    = 4'($urandom);
                    bus.req_data[i*32 +: 32] = $urandom;
                end
            end
            bus.bus_ready = ($urandom_range(0, 4) != 0);
            bus.flush     = ($urandom_range(0, 9) == 0);
            #2;
            exp_g = model_grant();
            n_tests++;
            if (bus.grant !== exp_g) begin
                n_fail++; $display("FAIL rand_grant c=%0d got=%b want=%b", c, bus.grant, exp_g);
            end
            last_g = exp_g;
            tick();
            n_tests++;
            if (bus.cdb_valid !== m_valid || bus.cdb_tag !== m_tag || bus.cdb_data !== m_data
                || (m_valid && bus.cdb_src !== m_src)) begin
                n_fail++;
                $display("FAIL rand_cdb c=%0d got v=%b t=%h d=%h s=%b want v=%b t=%h d=%h s=%b",
                         c, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src,
                         m_valid, m_tag, m_data, m_src);
            end
        end
        bus.flush = 1'b0;
        bus.bus_ready = 1'b1;
    endtask

    initial begin
        m_ptr = 0; m_valid = 1'b0; m_tag = 4'd0; m_data = 32'd0; m_src = 4'd0;
        reset = 1'b1;
        bus.req = 4'd0; bus.req_tag = '0; bus.req_data = '0;
        bus.bus_ready = 1'b1; bus.flush = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_rotation();
        test_single();
        test_stall_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
